// File: rtl/pprm_inv_arbiter.sv
// Four-requester round-robin front end sharing one GF(2^8) inverter between
// two pipeline registers (S1 -> inverter -> S2), with ready/valid flow control.

module pprm_inverter (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Multiplication in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) begin
                acc = acc ^ p;
            end
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
        end
        return acc;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128; this is the inverse and maps 0 to 0.
    always_comb begin
        logic [7:0] sq;
        logic [7:0] prod;
        sq   = a;
        prod = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq   = gf_mul(sq, sq);
            prod = gf_mul(prod, sq);
        end
        y = prod;
    end
endmodule

module pprm_inv_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic [1:0]  out_id,
    input  logic        out_ready
);
    logic       v1_q, v1_d;
    logic [7:0] d1_q, d1_d;
    logic [1:0] id1_q, id1_d;
    logic       v2_q, v2_d;
    logic [7:0] y2_q, y2_d;
    logic [1:0] id2_q, id2_d;
    logic [1:0] last_gnt_q, last_gnt_d;

    logic       adv1;
    logic       adv2;
    logic       gnt_found;
    logic [1:0] gnt_idx;
    logic [7:0] gnt_data;
    logic       accept;
    logic [7:0] inv_y;

    pprm_inverter u_inv (
        .a (d1_q),
        .y (inv_y)
    );

    assign adv2 = !v2_q || out_ready;
    assign adv1 = !v1_q || adv2;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        logic [1:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = last_gnt_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_gnt_q + 2'(k);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign gnt_data = req_data[{gnt_idx, 3'b000} +: 8];

    // rst gates the handshake so nothing is offered while reset is held.
    assign accept = adv1 && gnt_found && !rst;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ready
            assign req_ready[gi] = accept && (gnt_idx == 2'(gi));
        end
    endgenerate

    always_comb begin
        v1_d       = v1_q;
        d1_d       = d1_q;
        id1_d      = id1_q;
        v2_d       = v2_q;
        y2_d       = y2_q;
        id2_d      = id2_q;
        last_gnt_d = last_gnt_q;
        if (adv1) begin
            v1_d = gnt_found;
            if (gnt_found) begin
                d1_d  = gnt_data;
                id1_d = gnt_idx;
            end
        end
        if (adv2) begin
            v2_d  = v1_q;
            y2_d  = inv_y;
            id2_d = id1_q;
        end
        if (accept) begin
            last_gnt_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q       <= 1'b0;
            d1_q       <= 8'h00;
            id1_q      <= 2'd0;
            v2_q       <= 1'b0;
            y2_q       <= 8'h00;
            id2_q      <= 2'd0;
            last_gnt_q <= 2'd3;
        end else begin
            v1_q       <= v1_d;
            d1_q       <= d1_d;
            id1_q      <= id1_d;
            v2_q       <= v2_d;
            y2_q       <= y2_d;
            id2_q      <= id2_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    assign out_valid = v2_q;
    assign out_data  = y2_q;
    assign out_id    = id2_q;
endmodule

// File: tb/tb_pprm_inv_arbiter.sv
// Scoreboard bench for pprm_inv_arbiter: a per-cycle monitor predicts grants,
// output timing and inverse values from an independent brute-force GF(2^8) model.

module tb_pprm_inv_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;

    pprm_inv_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        int         acc;
    } sb_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } pend_t;

    sb_t        sb[$];
    pend_t      pend_q[$];
    int         glog[$];
    int         olog[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pops = 0;
    int         mode = 0;
    int         model_last = 3;
    bit         stall_prev = 0;
    logic [7:0] prev_data;
    logic [1:0] prev_id;
    logic [7:0] last_out;
    logic [1:0] last_id;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Carry-less product then reduction by 0x11B, independent of any shift-and-add form.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int j = 14; j >= 8; j--) begin
            if (p[j]) p = p ^ (15'h11B << (j - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        if (a != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (ref_mul(a, 8'(y)) == 8'h01) r = 8'(y);
            end
        end
        return r;
    endfunction

    task automatic drive();
        req_valid = 4'b0000;
        req_data  = $urandom;
        for (int id = 0; id < 4; id++) begin
            for (int i = 0; i < pend_q.size(); i++) begin
                if (pend_q[i].id == 2'(id)) begin
                    req_valid[id]          = 1'b1;
                    req_data[id * 8 +: 8]  = pend_q[i].data;
                    break;
                end
            end
        end
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic monitor();
        int  count;
        bit  exp_ov;
        bit  exp_any;
        int  g;
        sb_t e;
        count  = sb.size();
        exp_ov = (count > 0) && (cyc >= sb[0].acc + 2);
        check_eq("out_valid", out_valid, exp_ov);
        if (stall_prev) begin
            check_eq("stall_data", out_data, prev_data);
            check_eq("stall_id", out_id, prev_id);
        end
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
        prev_id    = out_id;
        exp_any = (|req_valid) && ((count < 2) || out_ready);
        check_eq("ready_any", |req_ready, exp_any);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("spurious_out", out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check_eq("out_data", out_data, e.data);
                check_eq("out_id", out_id, e.id);
                $display("OUT cyc=%0d id=%0d data=%02h exp_id=%0d exp_data=%02h",
                         cyc, out_id, out_data, e.id, e.data);
                last_out = out_data;
                last_id  = out_id;
                olog.push_back(int'(out_id));
                pops++;
            end
        end
        if (exp_any) begin
            g = -1;
            for (int k = 1; k <= 4 && g < 0; k++) begin
                if (req_valid[(model_last + k) % 4]) g = (model_last + k) % 4;
            end
            check_eq("grant", req_ready, 4'b0001 << g);
            if (req_ready[g]) begin
                e.id   = 2'(g);
                e.data = ref_inv(req_data[g * 8 +: 8]);
                e.acc  = cyc;
                sb.push_back(e);
                for (int i = 0; i < pend_q.size(); i++) begin
                    if (pend_q[i].id == 2'(g)) begin
                        pend_q.delete(i);
                        break;
                    end
                end
                model_last = g;
                glog.push_back(g);
            end
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        if (!rst) monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic push_req(input int id, input logic [7:0] data);
        pend_t p;
        p.id   = 2'(id);
        p.data = data;
        pend_q.push_back(p);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((pend_q.size() != 0 || sb.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check_eq("drained", (pend_q.size() == 0 && sb.size() == 0), 1'b1);
    endtask

    task automatic clear_model();
        pend_q.delete();
        sb.delete();
        model_last = 3;
        stall_prev = 0;
    endtask

    initial begin
        int t0;
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'd0;
        out_ready = 1'b0;
        push_req(1, 8'h10);
        repeat (2) step();
        // Reset values with a request already waiting.
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_data", out_data, 8'h00);
        check_eq("rst_out_id", out_id, 2'd0);
        check_eq("rst_req_ready", req_ready, 4'b0000);
        rst = 1'b0;
        wait_drain(20);

        // Single request, then round-trip of its inverse.
        push_req(0, 8'h53);
        wait_drain(20);
        check_eq("single_id", last_id, 2'd0);
        push_req(0, last_out);
        wait_drain(20);
        check_eq("roundtrip", last_out, 8'h53);

        // Zero operand.
        push_req(2, 8'h00);
        wait_drain(20);
        check_eq("zero_data", last_out, 8'h00);
        check_eq("zero_id", last_id, 2'd2);

        // Fairness from reset with all requesters continuously valid.
        rst = 1'b1;
        clear_model();
        repeat (2) step();
        rst = 1'b0;
        glog.delete();
        olog.delete();
        for (int n = 0; n < 5; n++) begin
            for (int id = 0; id < 4; id++) push_req(id, 8'(16 * n + id + 1));
        end
        t0 = cyc;
        wait_drain(60);
        check_eq("fair_cycles_ok", (cyc - t0) <= 24, 1'b1);
        for (int k = 0; k < 20; k++) begin
            check_eq("fair_grant", glog[k], k % 4);
            check_eq("fair_outid", olog[k], k % 4);
        end

        // Backpressure: two buffered, third held off until drain.
        mode = 1;
        olog.delete();
        push_req(0, 8'hA1);
        push_req(1, 8'hB2);
        push_req(2, 8'hC3);
        repeat (6) step();
        check_eq("bp_accepted", sb.size(), 2);
        check_eq("bp_pending", pend_q.size(), 1);
        check_eq("bp_ready_low", req_ready, 4'b0000);
        mode = 0;
        wait_drain(20);
        check_eq("bp_order0", olog[0], 0);
        check_eq("bp_order1", olog[1], 1);
        check_eq("bp_order2", olog[2], 2);

        // Asynchronous reset with both stages full.
        mode = 1;
        push_req(1, 8'h11);
        push_req(3, 8'h33);
        push_req(2, 8'h22);
        repeat (5) step();
        check_eq("mf_full", sb.size(), 2);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mf_out_valid", out_valid, 1'b0);
        check_eq("mf_out_data", out_data, 8'h00);
        check_eq("mf_req_ready", req_ready, 4'b0000);
        clear_model();
        repeat (3) step();
        rst = 1'b0;
        glog.delete();
        push_req(3, 8'h44);
        push_req(0, 8'h55);
        push_req(1, 8'h66);
        mode = 0;
        wait_drain(20);
        check_eq("mf_first_grant", glog[0], 0);

        // All 256 operands through random requesters, random out_ready.
        mode = 2;
        t0 = pops;
        for (int x = 0; x < 256; x++) push_req($urandom_range(0, 3), 8'(x));
        wait_drain(5000);
        check_eq("exh_count", pops - t0, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
